// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: 8N1 serial receiver with a show-ahead byte FIFO.
// The rx line is oversampled at OVERSAMPLE x baud. Recovered bytes are pushed
// into a 2**FIFO_AW deep FIFO that the CPU pops through rd_en.
// Ports:
//   clk        system clock, all logic on posedge
//   rst        asynchronous active-low reset
//   rx         asynchronous serial input, idle high
//   rd_en      pop request, ignored when empty
//   rd_data    FIFO head byte, valid while empty=0
//   empty      FIFO holds no bytes
//   full       FIFO holds 2**FIFO_AW bytes
//   overrun    sticky: a byte was dropped because the FIFO was full
//   frame_err  sticky: a stop bit was sampled low
module uart_rx_fifo #(
  parameter int SYS_CLK_FREQ = 100000000,
  parameter int BAUD_RATE    = 115200,
  parameter int OVERSAMPLE   = 16,
  parameter int FIFO_AW      = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  input  logic       rd_en,
  output logic [7:0] rd_data,
  output logic       empty,
  output logic       full,
  output logic       overrun,
  output logic       frame_err
);

  localparam int DIV_RAW = SYS_CLK_FREQ / (BAUD_RATE * OVERSAMPLE);
  localparam int DIV     = (DIV_RAW < 1) ? 1 : DIV_RAW;
  localparam int DW      = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int SW      = $clog2(OVERSAMPLE);
  localparam int DEPTH   = 2 ** FIFO_AW;

  // Extra BREAK state holds off start detection after a framing error until
  // the line has returned high.
  typedef enum logic [2:0] {IDLE, START, DATA, STOP, BREAK} state_t;

  state_t          state, state_n;
  logic [DW-1:0]   div_cnt;
  logic            tick;
  logic            rx_m, rx_s;
  logic [SW-1:0]   scnt, scnt_n;
  logic [2:0]      bcnt, bcnt_n;
  logic [7:0]      shreg, shreg_n;
  logic            push_n, push_v, ferr_set;

  logic [FIFO_AW:0]   wptr, rptr, rptr_n;
  logic [7:0]         mem [DEPTH];
  logic               do_pop, do_push;

  // Free-running tick divider.
  assign tick = (div_cnt == DW'(DIV - 1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      div_cnt <= '0;
    end else if (tick) begin
      div_cnt <= '0;
    end else begin
      div_cnt <= div_cnt + 1'b1;
    end
  end

  // Two-flop synchronizer, reset to idle level.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rx_m <= 1'b1;
      rx_s <= 1'b1;
    end else begin
      rx_m <= rx;
      rx_s <= rx_m;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= IDLE;
      scnt   <= '0;
      bcnt   <= '0;
      shreg  <= '0;
      push_v <= 1'b0;
    end else begin
      state  <= state_n;
      scnt   <= scnt_n;
      bcnt   <= bcnt_n;
      shreg  <= shreg_n;
      push_v <= push_n;
    end
  end

  always_comb begin
    state_n  = state;
    scnt_n   = scnt;
    bcnt_n   = bcnt;
    shreg_n  = shreg;
    push_n   = 1'b0;
    ferr_set = 1'b0;
    if (tick) begin
      case (state)
        IDLE: begin
          if (!rx_s) begin
            state_n = START;
            scnt_n  = '0;
          end
        end
        START: begin
          if (scnt == SW'(OVERSAMPLE / 2 - 1)) begin
            if (!rx_s) begin
              state_n = DATA;
              scnt_n  = '0;
              bcnt_n  = '0;
            end else begin
              state_n = IDLE;
            end
          end else begin
            scnt_n = scnt + 1'b1;
          end
        end
        DATA: begin
          if (scnt == SW'(OVERSAMPLE - 1)) begin
            shreg_n = {rx_s, shreg[7:1]};
            scnt_n  = '0;
            if (bcnt == 3'd7) begin
              state_n = STOP;
            end else begin
              bcnt_n = bcnt + 1'b1;
            end
          end else begin
            scnt_n = scnt + 1'b1;
          end
        end
        STOP: begin
          if (scnt == SW'(OVERSAMPLE - 1)) begin
            scnt_n = '0;
            if (rx_s) begin
              push_n  = 1'b1;
              state_n = IDLE;
            end else begin
              ferr_set = 1'b1;
              state_n  = BREAK;
            end
          end else begin
            scnt_n = scnt + 1'b1;
          end
        end
        BREAK: begin
          if (rx_s) begin
            state_n = IDLE;
          end
        end
        default: state_n = IDLE;
      endcase
    end
  end

  // FIFO: pointer MSB separates full from empty.
  assign empty   = (wptr == rptr);
  assign full    = (wptr[FIFO_AW] != rptr[FIFO_AW]) &&
                   (wptr[FIFO_AW-1:0] == rptr[FIFO_AW-1:0]);
  assign do_pop  = rd_en & ~empty;
  assign do_push = push_v & (~full | do_pop);
  assign rptr_n  = do_pop ? rptr + 1'b1 : rptr;

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wptr[FIFO_AW-1:0]] <= shreg;
    end
  end

  // rd_data tracks the post-update head; a byte written into the slot that
  // becomes the head this cycle is forwarded directly.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wptr      <= '0;
      rptr      <= '0;
      rd_data   <= '0;
      overrun   <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      if (do_push) begin
        wptr <= wptr + 1'b1;
      end
      rptr <= rptr_n;
      if (do_push || do_pop) begin
        if (do_push && (wptr[FIFO_AW-1:0] == rptr_n[FIFO_AW-1:0])) begin
          rd_data <= shreg;
        end else begin
          rd_data <= mem[rptr_n[FIFO_AW-1:0]];
        end
      end
      if (push_v && full && !do_pop) begin
        overrun <= 1'b1;
      end
      if (ferr_set) begin
        frame_err <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Testbench for uart_rx_fifo with DIV=1 (one bit = 16 clk).
module tb_uart_rx_fifo;

  logic       clk = 1'b0;
  logic       rst;
  logic       rx;
  logic       rd_en;
  logic [7:0] rd_data;
  logic       empty, full, overrun, frame_err;

  uart_rx_fifo #(
    .SYS_CLK_FREQ(16),
    .BAUD_RATE   (1),
    .OVERSAMPLE  (16),
    .FIFO_AW     (3)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .rx       (rx),
    .rd_en    (rd_en),
    .rd_data  (rd_data),
    .empty    (empty),
    .full     (full),
    .overrun  (overrun),
    .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: a byte queue plus sticky flags.
  logic [7:0] q[$];
  bit         m_ovr;
  bit         m_ferr;

  int cyc = 0;
  int start_cyc = 0;
  int fall_cyc = -1;
  logic prev_empty = 1'b1;

  always @(posedge clk) cyc++;
  always @(negedge clk) begin
    if (prev_empty === 1'b1 && empty === 1'b0) fall_cyc = cyc;
    prev_empty = empty;
  end

  typedef struct {
    logic [7:0] data;
    bit         stop_ok;
    int         npop;
    int         exp_cnt;
    logic [7:0] exp_head;
    bit         exp_ferr;
  } vec_t;

  vec_t vecs[6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_model(input string name);
    chk({name, ".empty"}, empty, q.size() == 0);
    chk({name, ".full"}, full, q.size() == 8);
    if (q.size() > 0) chk({name, ".rd_data"}, rd_data, q[0]);
    chk({name, ".overrun"}, overrun, m_ovr);
    chk({name, ".frame_err"}, frame_err, m_ferr);
  endtask

  task automatic model_clear();
    q.delete();
    m_ovr  = 1'b0;
    m_ferr = 1'b0;
  endtask

  task automatic do_reset(input logic rx_during);
    rst = 1'b0;
    rx  = rx_during;
    repeat (10) @(negedge clk);
    chk("rst.empty", empty, 1);
    chk("rst.full", full, 0);
    chk("rst.overrun", overrun, 0);
    chk("rst.frame_err", frame_err, 0);
    chk("rst.rd_data", rd_data, 0);
    rx  = 1'b1;
    rst = 1'b1;
    model_clear();
    repeat (40) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] d, input bit stop_ok);
    start_cyc = cyc;
    rx = 1'b0;
    repeat (16) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = d[i];
      repeat (16) @(negedge clk);
    end
    rx = stop_ok;
    repeat (16) @(negedge clk);
    rx = 1'b1;
    repeat (4) @(negedge clk);
    if (stop_ok) begin
      if (q.size() < 8) q.push_back(d);
      else m_ovr = 1'b1;
    end else begin
      m_ferr = 1'b1;
    end
  endtask

  task automatic pop();
    rd_en = 1'b1;
    @(negedge clk);
    rd_en = 1'b0;
    if (q.size() > 0) void'(q.pop_front());
    @(negedge clk);
  endtask

  initial begin
    vecs[0] = '{8'h5A, 1'b1, 0, 1, 8'h5A, 1'b0};
    vecs[1] = '{8'hC3, 1'b1, 1, 2, 8'h5A, 1'b0};
    vecs[2] = '{8'h0F, 1'b0, 0, 1, 8'hC3, 1'b1};
    vecs[3] = '{8'hF0, 1'b1, 2, 2, 8'hC3, 1'b1};
    vecs[4] = '{8'h01, 1'b1, 0, 1, 8'h01, 1'b1};
    vecs[5] = '{8'h80, 1'b1, 2, 2, 8'h01, 1'b1};

    rst   = 1'b0;
    rx    = 1'b0;
    rd_en = 1'b0;
    model_clear();

    // Reset with rx low, release with rx high: nothing received.
    do_reset(1'b0);
    check_model("t1");

    // Single byte and latency.
    fall_cyc = -1;
    send_frame(8'hA5, 1'b1);
    chk("t2.latency_ok", (fall_cyc >= 0) && (fall_cyc - start_cyc <= 164), 1);
    check_model("t2");
    pop();
    check_model("t2.pop");

    // Fill past depth.
    for (int i = 0; i < 9; i++) begin
      send_frame(8'(i), 1'b1);
      if (i == 7) chk("t3.full_at_7", full, 1);
      check_model("t3.fill");
    end
    chk("t3.overrun", overrun, 1);
    for (int i = 0; i < 8; i++) begin
      chk("t3.head", rd_data, 32'(i));
      pop();
    end
    chk("t3.drained", empty, 1);

    // Framing error then recovery.
    do_reset(1'b1);
    send_frame(8'h3C, 1'b0);
    chk("t4.frame_err", frame_err, 1);
    chk("t4.empty", empty, 1);
    repeat (16) @(negedge clk);
    send_frame(8'h5A, 1'b1);
    check_model("t4.next");

    // Short glitch.
    do_reset(1'b1);
    rx = 1'b0;
    repeat (4) @(negedge clk);
    rx = 1'b1;
    repeat (40) @(negedge clk);
    check_model("t5");

    // Reset mid-DATA.
    rx = 1'b0;
    repeat (16) @(negedge clk);
    rx = 1'b1;
    repeat (48) @(negedge clk);
    rst = 1'b0;
    repeat (5) @(negedge clk);
    rst = 1'b1;
    model_clear();
    repeat (20) @(negedge clk);
    send_frame(8'h81, 1'b1);
    chk("t6.one_byte_head", rd_data, 8'h81);
    check_model("t6");
    pop();
    chk("t6.only_one", empty, 1);

    // Table-driven vectors.
    do_reset(1'b1);
    for (int v = 0; v < 6; v++) begin
      send_frame(vecs[v].data, vecs[v].stop_ok);
      chk("tab.empty", empty, vecs[v].exp_cnt == 0);
      chk("tab.head", rd_data, vecs[v].exp_head);
      chk("tab.frame_err", frame_err, vecs[v].exp_ferr);
      check_model("tab");
      for (int p = 0; p < vecs[v].npop; p++) pop();
      check_model("tab.pop");
    end

    // Randomized traffic against the model.
    do_reset(1'b1);
    for (int r = 0; r < 30; r++) begin
      send_frame(8'($urandom), ($urandom_range(7) != 0));
      check_model("rnd");
      for (int p = 0; p < int'($urandom_range(1)); p++) pop();
      check_model("rnd.pop");
      if (!rx) repeat (16) @(negedge clk);
    end
    while (q.size() > 0) begin
      pop();
      check_model("rnd.drain");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
